// File: rtl/irq_vector_ctrl.sv
// Interrupt vector controller: arbitrates masked pending sources, presents one vector to the CPU
// and pulses a one-hot clear to the serviced source. Define IRQ_VECTOR_CTRL_ROUND_ROBIN_EN for round-robin arbitration.
module irq_vector_ctrl #(
    parameter int NUM_SRC = 8,
    parameter int VEC_W   = 3
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_SRC-1:0] irq_pend_i,
    input  logic [NUM_SRC-1:0] irq_mask_i,
    output logic               cpu_irq_o,
    output logic [VEC_W-1:0]   cpu_vec_o,
    input  logic               cpu_ack_i,
    input  logic               cpu_eoi_i,
    output logic [NUM_SRC-1:0] src_clear_o,
    output logic               busy_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SVC  = 2'd2,
        CLR  = 2'd3
    } state_e;

    state_e               state_q;
    logic                 cpu_irq_q;
    logic [VEC_W-1:0]     vec_q;
    logic [NUM_SRC-1:0]   src_clear_q;
    logic                 busy_q;

    logic [NUM_SRC-1:0]   eligible_s;
    logic                 any_eligible_s;
    logic                 winner_live_s;
    logic [VEC_W-1:0]     winner_s;
    logic                 found_s;
    logic [VEC_W-1:0]     idx_s;

`ifdef IRQ_VECTOR_CTRL_ROUND_ROBIN_EN
    localparam logic [VEC_W:0] NUM_SRC_W = (VEC_W+1)'(NUM_SRC);
    logic [VEC_W-1:0]     rr_ptr_q;
    logic [VEC_W-1:0]     rr_ptr_d;
    logic [VEC_W:0]       rr_sum_s;
`endif

    function automatic logic [NUM_SRC-1:0] onehot(input logic [VEC_W-1:0] idx);
        logic [NUM_SRC-1:0] r;
        r      = {NUM_SRC{1'b0}};
        r[idx] = 1'b1;
        return r;
    endfunction

    assign eligible_s     = irq_pend_i & irq_mask_i;
    assign any_eligible_s = |eligible_s;
    assign winner_live_s  = eligible_s[vec_q];

    // Arbitration: scan starting at the pointer (round-robin) or at index 0 (fixed priority).
    always_comb begin
        winner_s = {VEC_W{1'b0}};
        found_s  = 1'b0;
        idx_s    = {VEC_W{1'b0}};
`ifdef IRQ_VECTOR_CTRL_ROUND_ROBIN_EN
        rr_sum_s = {(VEC_W+1){1'b0}};
`endif
        for (int i = 0; i < NUM_SRC; i++) begin
`ifdef IRQ_VECTOR_CTRL_ROUND_ROBIN_EN
            rr_sum_s = {1'b0, rr_ptr_q} + (VEC_W+1)'(i);
            if (rr_sum_s >= NUM_SRC_W) begin
                rr_sum_s = rr_sum_s - NUM_SRC_W;
            end else begin
                rr_sum_s = rr_sum_s;
            end
            idx_s = rr_sum_s[VEC_W-1:0];
`else
            idx_s = VEC_W'(i);
`endif
            if (!found_s && eligible_s[idx_s]) begin
                winner_s = idx_s;
                found_s  = 1'b1;
            end else begin
                found_s  = found_s;
            end
        end
    end

`ifdef IRQ_VECTOR_CTRL_ROUND_ROBIN_EN
    // Next search start is one past the vector being cleared, wrapping at NUM_SRC.
    always_comb begin
        if (vec_q == VEC_W'(NUM_SRC - 1)) begin
            rr_ptr_d = {VEC_W{1'b0}};
        end else begin
            rr_ptr_d = vec_q + {{(VEC_W-1){1'b0}}, 1'b1};
        end
    end
`endif

    // Transaction FSM with registered outputs; withdrawal in REQ takes precedence over ACK.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cpu_irq_q   <= 1'b0;
            vec_q       <= {VEC_W{1'b0}};
            src_clear_q <= {NUM_SRC{1'b0}};
            busy_q      <= 1'b0;
`ifdef IRQ_VECTOR_CTRL_ROUND_ROBIN_EN
            rr_ptr_q    <= {VEC_W{1'b0}};
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    src_clear_q <= {NUM_SRC{1'b0}};
                    if (any_eligible_s) begin
                        state_q   <= REQ;
                        cpu_irq_q <= 1'b1;
                        vec_q     <= winner_s;
                        busy_q    <= 1'b1;
                    end else begin
                        state_q   <= IDLE;
                        cpu_irq_q <= 1'b0;
                        busy_q    <= 1'b0;
                    end
                end
                REQ: begin
                    if (!winner_live_s) begin
                        state_q   <= IDLE;
                        cpu_irq_q <= 1'b0;
                        busy_q    <= 1'b0;
                    end else if (cpu_ack_i) begin
                        state_q   <= SVC;
                        cpu_irq_q <= 1'b0;
                    end else begin
                        state_q   <= REQ;
                    end
                end
                SVC: begin
                    if (cpu_eoi_i) begin
                        state_q     <= CLR;
                        src_clear_q <= onehot(vec_q);
                    end else begin
                        state_q     <= SVC;
                    end
                end
                CLR: begin
                    state_q     <= IDLE;
                    src_clear_q <= {NUM_SRC{1'b0}};
                    busy_q      <= 1'b0;
`ifdef IRQ_VECTOR_CTRL_ROUND_ROBIN_EN
                    rr_ptr_q    <= rr_ptr_d;
`endif
                end
                default: begin
                    state_q     <= IDLE;
                    cpu_irq_q   <= 1'b0;
                    src_clear_q <= {NUM_SRC{1'b0}};
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign cpu_irq_o   = cpu_irq_q;
    assign cpu_vec_o   = vec_q;
    assign src_clear_o = src_clear_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_irq_vector_ctrl.sv
// Directed, table-driven bench for irq_vector_ctrl plus hand-written multi-cycle sequences.
// Expectations adapt to IRQ_VECTOR_CTRL_ROUND_ROBIN_EN where arbitration order differs.
module tb_irq_vector_ctrl;

    logic       clk;
    logic       rst;
    logic [7:0] pend;
    logic [7:0] mask;
    logic       ack;
    logic       eoi;
    logic       cpu_irq;
    logic [2:0] cpu_vec;
    logic [7:0] src_clear;
    logic       busy;

    int total;
    int bad;

    typedef struct {
        logic [7:0] pend;
        logic [7:0] mask;
        logic       ack;
        logic       eoi;
        logic       irq;
        logic [2:0] vec;
        logic [7:0] clr;
        logic       busy;
    } vec_t;

    vec_t tbl [22];

`ifdef IRQ_VECTOR_CTRL_ROUND_ROBIN_EN
    localparam logic [2:0] VA = 3'd3;
    localparam logic [2:0] VB = 3'd1;
`else
    localparam logic [2:0] VA = 3'd1;
    localparam logic [2:0] VB = 3'd3;
`endif

    irq_vector_ctrl #(.NUM_SRC(8), .VEC_W(3)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .irq_pend_i  (pend),
        .irq_mask_i  (mask),
        .cpu_irq_o   (cpu_irq),
        .cpu_vec_o   (cpu_vec),
        .cpu_ack_i   (ack),
        .cpu_eoi_i   (eoi),
        .src_clear_o (src_clear),
        .busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [7:0] oh8(input logic [2:0] i);
        logic [7:0] r;
        r    = 8'h00;
        r[i] = 1'b1;
        return r;
    endfunction

    function automatic vec_t mk(input logic [7:0] p, input logic [7:0] m, input logic a, input logic e,
                                input logic irq, input logic [2:0] v, input logic [7:0] c, input logic b);
        vec_t t;
        t.pend = p; t.mask = m; t.ack = a; t.eoi = e;
        t.irq = irq; t.vec = v; t.clr = c; t.busy = b;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_txn(input logic [2:0] exp_vec, input string tag, output int waited);
        int n;
        n = 0;
        while (cpu_irq !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        waited = n;
        check({tag, " irq_up"}, 32'(cpu_irq), 32'd1);
        check({tag, " vec"}, 32'(cpu_vec), 32'(exp_vec));
        @(negedge clk); ack = 1'b1;
        @(posedge clk); #1;
        check({tag, " irq_drop"}, 32'(cpu_irq), 32'd0);
        @(negedge clk); ack = 1'b0; eoi = 1'b1;
        @(posedge clk); #1;
        check({tag, " clear"}, 32'(src_clear), 32'(oh8(exp_vec)));
        @(negedge clk); eoi = 1'b0;
        @(posedge clk); #1;
        check({tag, " clear_end"}, 32'(src_clear), 32'd0);
        check({tag, " busy_end"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [7:0] p2;
        logic [2:0] rr_exp [4];
        int         waited;

        total = 0;
        bad   = 0;
        p2    = 8'h0A & ~oh8(VA);

        tbl[0]  = mk(8'h04, 8'hFF, 1'b0, 1'b0, 1'b1, 3'd2, 8'h00, 1'b1);
        tbl[1]  = mk(8'h04, 8'hFF, 1'b1, 1'b0, 1'b0, 3'd2, 8'h00, 1'b1);
        tbl[2]  = mk(8'h04, 8'hFF, 1'b0, 1'b0, 1'b0, 3'd2, 8'h00, 1'b1);
        tbl[3]  = mk(8'h04, 8'hFF, 1'b0, 1'b1, 1'b0, 3'd2, 8'h04, 1'b1);
        tbl[4]  = mk(8'h00, 8'hFF, 1'b0, 1'b0, 1'b0, 3'd2, 8'h00, 1'b0);
        tbl[5]  = mk(8'h0A, 8'hFF, 1'b0, 1'b0, 1'b1, VA,   8'h00, 1'b1);
        tbl[6]  = mk(8'h0A, 8'hFF, 1'b1, 1'b0, 1'b0, VA,   8'h00, 1'b1);
        tbl[7]  = mk(8'h0A, 8'hFF, 1'b0, 1'b1, 1'b0, VA,   oh8(VA), 1'b1);
        tbl[8]  = mk(p2,    8'hFF, 1'b0, 1'b0, 1'b0, VA,   8'h00, 1'b0);
        tbl[9]  = mk(p2,    8'hFF, 1'b0, 1'b0, 1'b1, VB,   8'h00, 1'b1);
        tbl[10] = mk(p2,    8'hFF, 1'b1, 1'b1, 1'b0, VB,   8'h00, 1'b1);
        tbl[11] = mk(p2,    8'hFF, 1'b0, 1'b0, 1'b0, VB,   8'h00, 1'b1);
        tbl[12] = mk(p2,    8'hFF, 1'b0, 1'b1, 1'b0, VB,   oh8(VB), 1'b1);
        tbl[13] = mk(8'h00, 8'hFF, 1'b0, 1'b0, 1'b0, VB,   8'h00, 1'b0);
        tbl[14] = mk(8'h00, 8'hFF, 1'b1, 1'b1, 1'b0, VB,   8'h00, 1'b0);
        tbl[15] = mk(8'h20, 8'hDF, 1'b0, 1'b0, 1'b0, VB,   8'h00, 1'b0);
        tbl[16] = mk(8'h20, 8'hFF, 1'b0, 1'b0, 1'b1, 3'd5, 8'h00, 1'b1);
        tbl[17] = mk(8'h20, 8'hFF, 1'b0, 1'b0, 1'b1, 3'd5, 8'h00, 1'b1);
        tbl[18] = mk(8'h20, 8'hFF, 1'b1, 1'b0, 1'b0, 3'd5, 8'h00, 1'b1);
        tbl[19] = mk(8'h20, 8'hFF, 1'b1, 1'b0, 1'b0, 3'd5, 8'h00, 1'b1);
        tbl[20] = mk(8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 3'd5, 8'h20, 1'b1);
        tbl[21] = mk(8'h00, 8'hFF, 1'b0, 1'b0, 1'b0, 3'd5, 8'h00, 1'b0);

`ifdef IRQ_VECTOR_CTRL_ROUND_ROBIN_EN
        rr_exp[0] = 3'd0; rr_exp[1] = 3'd1; rr_exp[2] = 3'd0; rr_exp[3] = 3'd1;
`else
        rr_exp[0] = 3'd0; rr_exp[1] = 3'd0; rr_exp[2] = 3'd0; rr_exp[3] = 3'd0;
`endif

        rst = 1'b1; pend = 8'h00; mask = 8'h00; ack = 1'b0; eoi = 1'b0;
        @(posedge clk); #1;
        check("reset irq", 32'(cpu_irq), 32'd0);
        check("reset vec", 32'(cpu_vec), 32'd0);
        check("reset clear", 32'(src_clear), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        @(negedge clk); rst = 1'b0;

        // Table: inputs applied before an edge, outputs compared just after it.
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            pend = tbl[i].pend; mask = tbl[i].mask; ack = tbl[i].ack; eoi = tbl[i].eoi;
            @(posedge clk); #1;
            check($sformatf("row%0d irq", i), 32'(cpu_irq), 32'(tbl[i].irq));
            check($sformatf("row%0d vec", i), 32'(cpu_vec), 32'(tbl[i].vec));
            check($sformatf("row%0d clear", i), 32'(src_clear), 32'(tbl[i].clr));
            check($sformatf("row%0d busy", i), 32'(busy), 32'(tbl[i].busy));
        end
        @(negedge clk); ack = 1'b0; eoi = 1'b0;

        // Two sources held pending across repeated transactions.
        pend = 8'h03; mask = 8'hFF;
        for (int k = 0; k < 4; k++) begin
            run_txn(rr_exp[k], $sformatf("rep%0d", k), waited);
            check($sformatf("rep%0d spacing", k), 32'(waited), 32'd1);
        end

        // Withdrawal by masking the winner while it is presented.
        @(negedge clk); pend = 8'h00;
        @(posedge clk); #1;
        @(negedge clk); pend = 8'h10;
        @(posedge clk); #1;
        check("wd irq", 32'(cpu_irq), 32'd1);
        check("wd vec", 32'(cpu_vec), 32'd4);
        @(negedge clk); mask = 8'hEF;
        @(posedge clk); #1;
        check("wd irq_drop", 32'(cpu_irq), 32'd0);
        check("wd busy", 32'(busy), 32'd0);
        check("wd clear", 32'(src_clear), 32'd0);
        @(posedge clk); #1;
        check("wd irq_stay", 32'(cpu_irq), 32'd0);
        check("wd clear_stay", 32'(src_clear), 32'd0);
        @(negedge clk); pend = 8'h00; mask = 8'hFF;

        // Reset pulse while servicing, pending source still set afterwards.
        @(negedge clk); pend = 8'h08;
        @(posedge clk); #1;
        check("rst irq", 32'(cpu_irq), 32'd1);
        @(negedge clk); ack = 1'b1;
        @(posedge clk); #1;
        check("rst in_svc busy", 32'(busy), 32'd1);
        @(negedge clk); ack = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rst async irq", 32'(cpu_irq), 32'd0);
        check("rst async vec", 32'(cpu_vec), 32'd0);
        check("rst async clear", 32'(src_clear), 32'd0);
        check("rst async busy", 32'(busy), 32'd0);
        eoi = 1'b1;
        @(posedge clk); #1;
        check("rst held clear", 32'(src_clear), 32'd0);
        check("rst held busy", 32'(busy), 32'd0);
        @(negedge clk); rst = 1'b0; eoi = 1'b0;
        @(posedge clk); #1;
        check("rst rerequest irq", 32'(cpu_irq), 32'd1);
        check("rst rerequest vec", 32'(cpu_vec), 32'd3);
        run_txn(3'd3, "post_rst", waited);
        @(negedge clk); pend = 8'h00;
        @(posedge clk); #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
